// File: rtl/milano_pkg.sv
// Shared types for the milano fetch path: buffered fetch entry, fetch FSM
// state encoding and an address alignment helper.
package milano_pkg;

  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [INSTR_W-1:0] pc;
    logic               err;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/milano_fetch_fifo.sv
// DEPTH-entry in-order buffer of fetched instructions sitting between the
// memory response path and decode. Flush wins over push and pop.
module milano_fetch_fifo
  import milano_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Storage is cleared on reset so the head outputs read as zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/milano_prefetch.sv
// Instruction prefetch unit: pipelined req/gnt/rvalid fetch into an in-order
// buffer, with branch redirects that flush and discard in-flight responses.
module milano_prefetch
  import milano_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INSTR_W-1:0] boot_addr_i,
  input  logic               fetch_en_i,
  input  logic               branch_i,
  input  logic [INSTR_W-1:0] branch_addr_i,
  output logic               instr_req_o,
  output logic [INSTR_W-1:0] instr_addr_o,
  input  logic               instr_gnt_i,
  input  logic               instr_rvalid_i,
  input  logic [INSTR_W-1:0] instr_rdata_i,
  input  logic               instr_err_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] rdata_o,
  output logic [INSTR_W-1:0] pc_o,
  output logic               err_o,
  input  logic               ready_i,
  output logic               busy_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t       state_reg, state_next;
  logic [INSTR_W-1:0] fetch_addr_reg;
  logic [INSTR_W-1:0] resp_pc_reg;
  logic [INSTR_W-1:0] target_reg;
  logic               target_pend_reg;
  logic               boot_pend_reg;
  logic [OW-1:0]      outstanding_reg, outstanding_next;
  logic [OW-1:0]      discard_reg, discard_next;
  logic [CW-1:0]      fifo_count, fifo_count_next;
  logic               fifo_empty;
  logic               fifo_full;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;
  logic               gnt_taken;
  logic               rsp;
  logic               drop;
  logic               keep;
  logic               pop;
  logic               credit;
  logic [INSTR_W-1:0] branch_target;
  logic [INSTR_W-1:0] boot_target;

  assign branch_target = word_align(branch_addr_i);
  assign boot_target   = word_align(boot_addr_i);

  // Responses with nothing outstanding are stale (e.g. after reset) and ignored.
  assign gnt_taken = (state_reg == FETCH_REQ) && instr_gnt_i;
  assign rsp       = instr_rvalid_i && (outstanding_reg != '0);
  assign drop      = rsp && (discard_reg != '0);
  assign pop       = !fifo_empty && ready_i;
  assign keep      = rsp && !drop && (!fifo_full || pop);

  always_comb begin
    outstanding_next = outstanding_reg + OW'(gnt_taken) - OW'(rsp);
    fifo_count_next  = branch_i ? '0 : (fifo_count + CW'(keep) - CW'(pop));
    credit = ((int'(fifo_count_next) + int'(outstanding_next)) < DEPTH) &&
             (int'(outstanding_next) < MAX_OUTSTANDING);

    // A request still waiting at branch time is owed a discard once granted.
    if (branch_i) begin
      discard_next = outstanding_next;
    end else begin
      discard_next = discard_reg - OW'(drop);
      if (gnt_taken && target_pend_reg) begin
        discard_next = discard_next + OW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_IDLE: begin
        if (fetch_en_i && !boot_pend_reg && credit) begin
          state_next = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (gnt_taken && !(credit && fetch_en_i)) begin
          state_next = FETCH_IDLE;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= FETCH_IDLE;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      boot_pend_reg   <= 1'b1;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      boot_pend_reg   <= 1'b0;
    end
  end

  // The request address only moves on gnt, so a redirect arriving while a
  // request waits is parked in target_reg until that request is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_reg  <= '0;
      target_reg      <= '0;
      target_pend_reg <= 1'b0;
    end else if (branch_i) begin
      if ((state_reg == FETCH_REQ) && !instr_gnt_i) begin
        target_reg      <= branch_target;
        target_pend_reg <= 1'b1;
      end else begin
        fetch_addr_reg  <= branch_target;
        target_pend_reg <= 1'b0;
      end
    end else if (gnt_taken) begin
      if (target_pend_reg) begin
        fetch_addr_reg  <= target_reg;
        target_pend_reg <= 1'b0;
      end else begin
        fetch_addr_reg <= fetch_addr_reg + 32'd4;
      end
    end else if (boot_pend_reg) begin
      fetch_addr_reg <= boot_target;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_pc_reg <= '0;
    end else if (branch_i) begin
      resp_pc_reg <= branch_target;
    end else if (boot_pend_reg) begin
      resp_pc_reg <= boot_target;
    end else if (keep) begin
      resp_pc_reg <= resp_pc_reg + 32'd4;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = instr_rdata_i;
    push_entry.pc   = resp_pc_reg;
    push_entry.err  = instr_err_i;
  end

  milano_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (keep),
    .wdata (push_entry),
    .pop   (pop),
    .flush (branch_i),
    .rdata (head_entry),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_req_o  = (state_reg == FETCH_REQ);
  assign instr_addr_o = fetch_addr_reg;
  assign valid_o      = !fifo_empty;
  assign rdata_o      = head_entry.data;
  assign pc_o         = head_entry.pc;
  assign err_o        = head_entry.err;
  assign busy_o       = (outstanding_reg != '0) || (discard_reg != '0);

endmodule
